reg_file: RTL and testbench
===========================

# reg_file

General-purpose register file for the TurtleMCU datapath, directly upstream of the ALU. Two combinational read ports drive the ALU's `arg_a` and `arg_b` operands. One synchronous write port accepts the ALU result for writeback. A separate flag register captures the ALU's `carry` and `zero` outputs for conditional branches.

## Interface
- `WIDTH`, 16, data width of each register; must equal the ALU operand width.
- `DEPTH`, 8, number of registers; must be a power of two, minimum 2.
- `AW`, $clog2(DEPTH) = 3, register address width; derived, never overridden.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `rd_addr_a`  in  AW  read port A address.
- `rd_data_a`  out  WIDTH  read port A data, feeds ALU `arg_a`.
- `rd_addr_b`  in  AW  read port B address.
- `rd_data_b`  out  WIDTH  read port B data, feeds ALU `arg_b`.
- `wr_en`  in  1  register write enable.
- `wr_addr`  in  AW  write address.
- `wr_data`  in  WIDTH  write data, normally the ALU `out`.
- `flag_we`  in  1  flag register write enable.
- `carry_in`  in  1  from ALU `carry`.
- `zero_in`  in  1  from ALU `zero`.
- `carry_q`  out  1  registered carry flag.
- `zero_q`  out  1  registered zero flag.

## Operation
- **Storage:** `DEPTH` × `WIDTH` flops, plus two flag flops. All registers are writable; there is no hardwired-zero register.
- **Reset:** on a rising edge with `rst_n`=0:
  - every register clears to 0; `carry_q`=0, `zero_q`=0.
  - `wr_en` and `flag_we` are ignored on that edge.
- **Reads:** purely combinational.
  - `rd_data_a` = reg[`rd_addr_a`]; `rd_data_b` = reg[`rd_addr_b`].
  - Both ports may address the same register and return identical data.
- **Write:** on a rising edge with `rst_n`=1 and `wr_en`=1, reg[`wr_addr`] ← `wr_data`. All other registers hold their value.
- **Flags:** on a rising edge with `rst_n`=1 and `flag_we`=1:
  - `carry_q` ← `carry_in`; `zero_q` ← `zero_in`.
  - Otherwise both flags hold.
- **Independence:** `wr_en` and `flag_we` are independent. Either, both or neither may be asserted in a cycle.
- **Write/read collision** (`wr_en`=1 and `wr_addr` equals a read address in the same cycle): behaviour is set by the bypass configuration below.
- **Unknowns:** no X propagation from unwritten registers, because reset initialises all of them.

## Timing
- Read latency: 0 cycles, combinational from address to data.
- Write latency: data is stored at the rising edge. Without bypass it appears on a read port in the cycle after that edge.
- Flag latency: `carry_q`/`zero_q` change at the edge where `flag_we`=1 and are valid from the following cycle.
- Reset latency: outputs read 0 from the cycle following the first rising edge with `rst_n`=0.
- Reset mid-operation: a write coincident with a reset edge is lost. Reset always wins.
- No handshake. The caller owns `wr_en`/`flag_we` and may assert them every cycle (one writeback per cycle sustained).

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** write-to-read forwarding is enabled.
  - When `wr_en`=1, `rst_n`=1 and `wr_addr`==`rd_addr_x`, `rd_data_x` = `wr_data` in the same cycle. This applies to each port independently.
  - Forwarding is suppressed while `rst_n`=0.
- **Undefined:** no forwarding. A read of the register being written returns the old stored value until the edge completes.
- Flags are never bypassed in either configuration.

## Test plan
- **Reset:** write 0xBEEF to r3, then hold `rst_n`=0 for one edge with `wr_en`=1, `wr_addr`=5, `wr_data`=0x1234.
  - Required: all registers read 0x0000, `carry_q`=0, `zero_q`=0, and r5 is still 0x0000.
- **Write/read:** write 0x00A5 to r2, then 0x5A00 to r7; read r2 on port A and r7 on port B.
  - Required: 0x00A5 and 0x5A00.
  - Reading r2 on both ports returns 0x00A5 on both.
- **Collision:** r4=0x1111; in one cycle drive `wr_en`=1, `wr_addr`=4, `wr_data`=0x2222 with `rd_addr_a`=4.
  - With `REGFILE_BYPASS_EN`: `rd_data_a`=0x2222 in that cycle.
  - Without it: 0x1111 in that cycle, 0x2222 in the next.
- **Flags:** `flag_we`=1, `carry_in`=1, `zero_in`=0 → next cycle `carry_q`=1, `zero_q`=0.
  - Then `flag_we`=0 with `carry_in`=0, `zero_in`=1 → flags hold at 1/0.
- **ALU loop:** r0=0xFFFF, r1=0x0001; read both into the ALU with ADD; write back to r2 with `flag_we`=1.
  - Required: r2=0x0000, `carry_q`=1, `zero_q`=1.
- **Back-to-back writes:** write r6 on 8 consecutive cycles with values 0x0001..0x0008.
  - Required: r6 reads 0x0008 afterwards and no other register changes.

Source files
------------

// File: rtl/reg_file.sv
// TurtleMCU general-purpose register file with two combinational read ports,
// one write port and carry/zero flag register. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             flag_we,
    input  logic             carry_in,
    input  logic             zero_in,
    output logic             carry_q,
    output logic             zero_q
);

    logic [WIDTH-1:0] regs [DEPTH];

    // Reset takes priority, so a write landing on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (flag_we) begin
            carry_q <= carry_in;
            zero_q  <= zero_in;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;
    assign fwd_ok = rst_n && wr_en;

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (fwd_ok && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (fwd_ok && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end
`else
    // Without forwarding a read of the register being written sees the old value.
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, hand sequences,
// and randomized traffic against an array-based reference model.
module tb_reg_file;

    localparam bit BYP =
`ifdef REGFILE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    localparam logic [15:0] COLL_EXP = BYP ? 16'h2222 : 16'h1111;

    logic        clk;
    logic        rst_n;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] rd_data_a, rd_data_b, wr_data;
    logic        wr_en, flag_we, carry_in, zero_in, carry_q, zero_q;

    reg_file dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flag_we   (flag_we),
        .carry_in  (carry_in),
        .zero_in   (zero_in),
        .carry_q   (carry_q),
        .zero_q    (zero_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    int total = 0;
    int passed = 0;

    logic [15:0] mdl [8];
    logic        mdl_c, mdl_z;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input logic r, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic fwe, input logic ci,
                         input logic zi, input logic [2:0] ra, input logic [2:0] rb);
        @(negedge clk);
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
        flag_we = fwe; carry_in = ci; zero_in = zi;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
    endtask

    // Reference behaviour at a rising edge, from the currently driven stimulus.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
            mdl_c = 1'b0;
            mdl_z = 1'b0;
        end else begin
            if (wr_en) mdl[wr_addr] = wr_data;
            if (flag_we) begin
                mdl_c = carry_in;
                mdl_z = zero_in;
            end
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [2:0] ra);
        if (BYP && rst_n && wr_en && (wr_addr == ra)) return wr_data;
        return mdl[ra];
    endfunction

    typedef struct {
        logic        r;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        fwe, ci, zi;
        logic [2:0]  ra, rb;
        logic [15:0] ea, eb;
        logic        ec, ez;
    } vec_t;

    vec_t tbl [13];
    logic [15:0] snap [8];
    logic [16:0] alu_sum;

    initial begin
        // Outputs checked just before the rising edge of each row.
        tbl[0]  = '{1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd5, 16'h1234, 1'b1, 1'b1, 1'b1, 3'd3, 3'd5, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd3, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 3'd2, 16'h00A5, 1'b0, 1'b0, 1'b0, 3'd7, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 3'd7, 16'h5A00, 1'b0, 1'b0, 1'b0, 3'd2, 3'd3, 16'h00A5, 16'h0000, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, 3'd7, 16'h00A5, 16'h5A00, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd2, 3'd2, 16'h00A5, 16'h00A5, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 3'd4, 16'h1111, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 3'd4, 16'h2222, 1'b0, 1'b0, 1'b0, 3'd4, 3'd2, COLL_EXP, 16'h00A5, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd4, 3'd4, 16'h2222, 16'h2222, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd4, 3'd7, 16'h2222, 16'h5A00, 1'b1, 1'b0};

        for (int i = 0; i < 8; i++) mdl[i] = 16'hXXXX;
        mdl_c = 1'bx;
        mdl_z = 1'bx;

        apply(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        tick();
        apply(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        tick();

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].r, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].fwe,
                  tbl[i].ci, tbl[i].zi, tbl[i].ra, tbl[i].rb);
            chk($sformatf("vec%0d_rd_a", i), rd_data_a, tbl[i].ea);
            chk($sformatf("vec%0d_rd_b", i), rd_data_b, tbl[i].eb);
            chk($sformatf("vec%0d_carry", i), carry_q, tbl[i].ec);
            chk($sformatf("vec%0d_zero", i), zero_q, tbl[i].ez);
            tick();
        end

        // ALU loop: r0 + r1 written to r2 with flags captured.
        apply(1'b1, 1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        tick();
        apply(1'b1, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        tick();
        apply(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1);
        chk("alu_arg_a", rd_data_a, 16'hFFFF);
        chk("alu_arg_b", rd_data_b, 16'h0001);
        alu_sum = {1'b0, rd_data_a} + {1'b0, rd_data_b};
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = alu_sum[15:0];
        flag_we = 1'b1; carry_in = alu_sum[16]; zero_in = (alu_sum[15:0] == 16'h0);
        tick();
        apply(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd2, 3'd2);
        chk("alu_r2", rd_data_a, 16'h0000);
        chk("alu_carry", carry_q, 1'b1);
        chk("alu_zero", zero_q, 1'b1);

        // Back-to-back writes to r6; nothing else may move.
        for (int r = 0; r < 8; r++) snap[r] = mdl[r];
        for (int v = 1; v <= 8; v++) begin
            apply(1'b1, 1'b1, 3'd6, 16'(v), 1'b0, 1'b0, 1'b0, 3'd6, 3'd0);
            tick();
        end
        for (int r = 0; r < 8; r++) begin
            apply(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'(r), 3'(7 - r));
            if (r == 6) chk("b2b_r6", rd_data_a, 16'h0008);
            else        chk($sformatf("b2b_r%0d", r), rd_data_a, snap[r]);
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(31) != 0), $urandom_range(1), 3'($urandom_range(7)),
                  16'($urandom), $urandom_range(1), $urandom_range(1), $urandom_range(1),
                  3'($urandom_range(7)), 3'($urandom_range(7)));
            chk($sformatf("rnd%0d_rd_a", n), rd_data_a, ref_rd(rd_addr_a));
            chk($sformatf("rnd%0d_rd_b", n), rd_data_b, ref_rd(rd_addr_b));
            chk($sformatf("rnd%0d_carry", n), carry_q, mdl_c);
            chk($sformatf("rnd%0d_zero", n), zero_q, mdl_z);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
